stream_serializer: RTL and testbench

- Width-down converter on a valid/ready stream.
- Accepts one wide word of NUM_BEATS*BEAT_W bits and emits it as NUM_BEATS consecutive narrow beats.
- Sits directly downstream of a stream register stage, consuming its output port and feeding a narrow link or FIFO.
- Holds one wide word internally, so it also cuts the data path from input to output.

---
 rtl/stream_serializer.sv | 108 ++++++++++
 tb/tb_stream_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_serializer.sv
// ---------------------------------------------------------------------------
// stream_serializer
//
// Width-down converter on a valid/ready stream. One wide word of
// NUM_BEATS*BEAT_W bits is captured and replayed as NUM_BEATS narrow beats.
// Only one word is held at a time. The data path is therefore registered
// from input to output. A new word may be accepted in the same cycle as the
// last beat of the current word leaves, so the stream has no bubble.
//
// Parameters:
//   BEAT_W    - width of one output beat (>= 1)
//   NUM_BEATS - beats per input word (>= 1; 1 gives a one-entry register)
//   MSB_FIRST - 0: least-significant slice first, 1: most-significant first
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   clr_i    in   synchronous clear; drops any held word
//   valid_i  in   input word valid
//   ready_o  out  block can accept an input word
//   data_i   in   input word, NUM_BEATS*BEAT_W bits
//   valid_o  out  output beat valid
//   ready_i  in   downstream accepts the beat
//   data_o   out  current output beat, BEAT_W bits
//   last_o   out  current beat is the final beat of its word
// ---------------------------------------------------------------------------
module stream_serializer #(
    parameter int   BEAT_W    = 8,
    parameter int   NUM_BEATS = 4,
    parameter logic MSB_FIRST = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [NUM_BEATS*BEAT_W-1:0] data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [BEAT_W-1:0]           data_o,
    output logic                        last_o
);

    localparam int WORD_W = NUM_BEATS * BEAT_W;
    localparam int CNT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    logic [WORD_W-1:0] word_p0;
    logic [CNT_W-1:0]  cnt_p0;
    logic              vld_p0;

    logic last_beat;
    logic in_hs;
    logic out_hs;

    // Select the beat addressed by the counter, honouring beat order.
    function automatic logic [BEAT_W-1:0] beat_slice(
        input logic [WORD_W-1:0] w,
        input logic [CNT_W-1:0]  c
    );
        int                idx;
        logic [WORD_W-1:0] sh;
        idx = MSB_FIRST ? (NUM_BEATS - 1 - int'(c)) : int'(c);
        sh  = w >> (idx * BEAT_W);
        return sh[BEAT_W-1:0];
    endfunction

    assign last_beat = vld_p0 && (cnt_p0 == LAST_CNT);

    // Ready also opens while the final beat is leaving, so a new word can be
    // taken in the same cycle. This keeps a combinational ready_i -> ready_o
    // path on purpose.
    assign ready_o = !vld_p0 || (last_beat && ready_i);
    assign in_hs   = valid_i && ready_o;
    assign out_hs  = vld_p0 && ready_i;

    // ---- stage p0: held word, beat counter and valid flag ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_p0 <= '0;
            cnt_p0  <= '0;
            vld_p0  <= 1'b0;
        end else if (clr_i) begin
            // Clear beats any handshake in the same cycle. The word contents
            // are left alone because they are ignored while vld_p0 is low.
            cnt_p0 <= '0;
            vld_p0 <= 1'b0;
        end else if (in_hs) begin
            // Either the block was empty, or the last beat is leaving now.
            word_p0 <= data_i;
            cnt_p0  <= '0;
            vld_p0  <= 1'b1;
        end else if (out_hs) begin
            if (last_beat) begin
                cnt_p0 <= '0;
                vld_p0 <= 1'b0;
            end else begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    // ---- output: beats come straight from the held word ----
    assign valid_o = vld_p0;
    assign last_o  = last_beat;
    assign data_o  = beat_slice(word_p0, cnt_p0);

endmodule

// File: tb/tb_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_stream_serializer
//
// Three serializers share the clock and reset:
//   inst 0: BEAT_W=8, NUM_BEATS=4, LSB first
//   inst 1: BEAT_W=8, NUM_BEATS=4, MSB first
//   inst 2: BEAT_W=8, NUM_BEATS=1
// Accepted words are expanded into expected beats in a per-instance queue.
// A monitor compares every cycle's outputs against the queue.
// ---------------------------------------------------------------------------
module tb_stream_serializer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [2:0]  clr;
    logic [2:0]  vi;
    logic [2:0]  ri;
    logic [31:0] di [3];
    wire  [2:0]  ro;
    wire  [2:0]  vo;
    wire  [2:0]  lo;
    wire  [7:0]  dout [3];

    int   errors = 0;
    int   checks = 0;
    logic rand_ready = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int   NB  = (g == 2) ? 1 : 4;
        localparam logic MSB = (g == 1) ? 1'b1 : 1'b0;

        // Expected beats of the held word: {last, data}.
        logic [8:0] q [$];

        stream_serializer #(
            .BEAT_W   (8),
            .NUM_BEATS(NB),
            .MSB_FIRST(MSB)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_ni),
            .clr_i  (clr[g]),
            .valid_i(vi[g]),
            .ready_o(ro[g]),
            .data_i (di[g][NB*8-1:0]),
            .valid_o(vo[g]),
            .ready_i(ri[g]),
            .data_o (dout[g]),
            .last_o (lo[g])
        );

        // Expand each accepted word into its beat sequence when it is taken.
        initial begin : push_proc
            forever begin
                @(posedge clk);
                if (rst_ni && !clr[g] && vi[g] && ro[g]) begin
                    for (int k = 0; k < NB; k++) begin
                        int          s;
                        logic [31:0] sh;
                        s  = MSB ? (NB - 1 - k) : k;
                        sh = di[g] >> (8 * s);
                        q.push_back({(k == NB - 1), sh[7:0]});
                    end
                end
            end
        end

        // The block is full exactly while the queue holds beats.
        initial begin : mon_proc
            int         sz;
            logic [8:0] head;
            logic       stall;
            logic [7:0] pd;
            logic       pl;
            stall = 1'b0;
            pd    = '0;
            pl    = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_ni) begin
                    chk("rst_valid", g, vo[g], 0);
                    chk("rst_last", g, lo[g], 0);
                    chk("rst_data", g, dout[g], 0);
                    chk("rst_ready", g, ro[g], 1);
                    q.delete();
                    stall = 1'b0;
                end else begin
                    sz = q.size();
                    chk("valid", g, vo[g], (sz != 0));
                    chk("ready", g, ro[g], (sz == 0) || (sz == 1 && ri[g]));
                    if (sz != 0) begin
                        head = q[0];
                        chk("data", g, dout[g], head[7:0]);
                        chk("last", g, lo[g], head[8]);
                    end
                    if (stall) begin
                        chk("stall_valid", g, vo[g], 1);
                        chk("stall_data", g, dout[g], pd);
                        chk("stall_last", g, lo[g], pl);
                    end
                    stall = vo[g] && !ri[g] && !clr[g];
                    pd    = dout[g];
                    pl    = lo[g];
                    if (clr[g])
                        q.delete();
                    else if (vo[g] && ri[g] && sz != 0)
                        void'(q.pop_front());
                end
            end
        end
    end

    // Offer one word and hold it until it is accepted.
    task automatic send(input int i, input logic [31:0] w);
        int   n;
        logic to;
        n  = 0;
        to = 1'b0;
        vi[i] = 1'b1;
        di[i] = w;
        @(negedge clk);
        while (!(ro[i] && rst_ni && !clr[i]) && !to) begin
            n++;
            if (n > 200) to = 1'b1;
            else @(negedge clk);
        end
        chk("send_timeout", i, to, 0);
        @(posedge clk);
        #1;
        vi[i] = 1'b0;
    endtask

    task automatic rand_run(input int i);
        repeat (40) begin
            int n;
            send(i, $urandom);
            n = $urandom_range(0, 2);
            if (n > 0) begin
                repeat (n) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Random downstream backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ri = 3'($urandom);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        clr    = '0;
        vi     = '0;
        ri     = '1;
        for (int i = 0; i < 3; i++) di[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("init_valid", i, vo[i], 0);
            chk("init_ready", i, ro[i], 1);
            chk("init_last", i, lo[i], 0);
            chk("init_data", i, dout[i], 0);
        end
        rst_ni = 1'b1;
        idle(2);

        // Basic single word.
        send(0, 32'hDDCCBBAA);
        idle(6);

        // Back-to-back words.
        send(0, 32'h44332211);
        send(0, 32'h88776655);
        idle(10);

        // Backpressure on the second beat for three cycles.
        send(0, 32'hDDCCBBAA);
        @(posedge clk);
        #1;
        chk("bp_beat", 0, dout[0], 8'hBB);
        ri[0] = 1'b0;
        idle(3);
        chk("bp_hold", 0, dout[0], 8'hBB);
        ri[0] = 1'b1;
        idle(6);

        // MSB-first order.
        send(1, 32'hDDCCBBAA);
        idle(6);

        // Clear while BB is held.
        send(0, 32'hDDCCBBAA);
        @(posedge clk);
        #1;
        chk("clr_pre", 0, dout[0], 8'hBB);
        ri[0] = 1'b0;
        idle(1);
        clr[0] = 1'b1;
        ri[0]  = 1'b1;
        idle(1);
        clr[0] = 1'b0;
        chk("clr_valid", 0, vo[0], 0);
        chk("clr_ready", 0, ro[0], 1);
        send(0, 32'h04030201);
        idle(6);

        // One-beat configuration, three consecutive words.
        send(2, 32'h5A);
        send(2, 32'h5A);
        send(2, 32'h5A);
        idle(4);

        // Asynchronous reset in the middle of a word.
        send(0, 32'hDDCCBBAA);
        chk("pre_rst_valid", 0, vo[0], 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 0, vo[0], 0);
        chk("arst_last", 0, lo[0], 0);
        chk("arst_data", 0, dout[0], 0);
        chk("arst_ready", 0, ro[0], 1);
        idle(2);
        rst_ni = 1'b1;
        idle(2);

        // Random traffic on all three instances.
        rand_ready = 1'b1;
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join
        rand_ready = 1'b0;
        idle(1);
        ri = '1;
        idle(20);
        chk("drain_q", 0, g_cfg[0].q.size(), 0);
        chk("drain_q", 1, g_cfg[1].q.size(), 0);
        chk("drain_q", 2, g_cfg[2].q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
